// File: rtl/tape_head_ctrl_if.sv
// Op channel between the instruction sequencer (master) and the tape head controller (slave).
interface tape_head_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              op_valid;
  logic [2:0]        op;
  logic              op_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;

  modport master (
    output op_valid, op, in_data,
    input  op_ready, out_valid, out_data
  );

  modport slave (
    input  op_valid, op, in_data,
    output op_ready, out_valid, out_data
  );
endinterface

// File: rtl/tape_head_ctrl.sv
// BF data-tape controller: owns the data pointer and cached cell, drives the tape memory port.
// Optional TAPE_BOUNDS_EN: pointer moves off either tape end are refused and flag a sticky err.
module tape_head_ctrl #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  tape_head_ctrl_if.slave     op_if,
  output logic [DATA_W-1:0]   cell_val,
  output logic                cell_zero,
  output logic [ADDR_W-1:0]   ptr,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_data,
  output logic                mem_wren,
  input  logic [DATA_W-1:0]   mem_q
`ifdef TAPE_BOUNDS_EN
  ,
  output logic                err
`endif
);

  localparam logic [1:0] ST_CLR     = 2'd0;
  localparam logic [1:0] ST_IDLE    = 2'd1;
  localparam logic [1:0] ST_FETCH   = 2'd2;
  localparam logic [1:0] ST_CAPTURE = 2'd3;

  localparam logic [2:0] OP_INC   = 3'd1;
  localparam logic [2:0] OP_DEC   = 3'd2;
  localparam logic [2:0] OP_RIGHT = 3'd3;
  localparam logic [2:0] OP_LEFT  = 3'd4;
  localparam logic [2:0] OP_OUT   = 3'd5;
  localparam logic [2:0] OP_IN    = 3'd6;

  localparam logic [1:0] RESET_STATE = CLEAR_ON_RESET ? ST_CLR : ST_IDLE;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] cell_q, cell_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              op_ready;
`ifdef TAPE_BOUNDS_EN
  logic              err_q, err_d;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    ptr_d       = ptr_q;
    cell_d      = cell_q;
    clr_cnt_d   = clr_cnt_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
`ifdef TAPE_BOUNDS_EN
    err_d       = err_q;
`endif
    op_ready    = 1'b0;
    mem_address = ptr_q;
    mem_data    = cell_q;
    mem_wren    = 1'b0;

    case (state_q)
      ST_CLR: begin
        mem_wren    = 1'b1;
        mem_data    = '0;
        mem_address = clr_cnt_q;
        clr_cnt_d   = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) state_d = ST_IDLE;
      end

      ST_IDLE: begin
        op_ready = 1'b1;
        if (op_if.op_valid) begin
          case (op_if.op)
            OP_INC, OP_DEC, OP_IN: begin
              // The cached cell is the forwarding source, so back-to-back writes see the latest value.
              if (op_if.op == OP_INC)      cell_d = cell_q + 1'b1;
              else if (op_if.op == OP_DEC) cell_d = cell_q - 1'b1;
              else                         cell_d = op_if.in_data;
              mem_data = cell_d;
              mem_wren = 1'b1;
            end
            OP_OUT: begin
              out_valid_d = 1'b1;
              out_data_d  = cell_q;
            end
            OP_RIGHT, OP_LEFT: begin
`ifdef TAPE_BOUNDS_EN
              if ((op_if.op == OP_RIGHT && ptr_q == '1) ||
                  (op_if.op == OP_LEFT  && ptr_q == '0)) begin
                err_d = 1'b1;
              end else begin
                ptr_d   = (op_if.op == OP_RIGHT) ? ptr_q + 1'b1 : ptr_q - 1'b1;
                state_d = ST_FETCH;
              end
`else
              ptr_d   = (op_if.op == OP_RIGHT) ? ptr_q + 1'b1 : ptr_q - 1'b1;
              state_d = ST_FETCH;
`endif
            end
            default: ;
          endcase
        end
      end

      ST_FETCH: state_d = ST_CAPTURE;

      ST_CAPTURE: begin
        cell_d  = mem_q;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= RESET_STATE;
      ptr_q       <= '0;
      cell_q      <= '0;
      clr_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef TAPE_BOUNDS_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cell_q      <= cell_d;
      clr_cnt_q   <= clr_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef TAPE_BOUNDS_EN
      err_q       <= err_d;
`endif
    end
  end

  assign op_if.op_ready  = op_ready;
  assign op_if.out_valid = out_valid_q;
  assign op_if.out_data  = out_data_q;
  assign cell_val        = cell_q;
  assign cell_zero       = (cell_q == '0);
  assign ptr             = ptr_q;
`ifdef TAPE_BOUNDS_EN
  assign err             = err_q;
`endif

endmodule

// File: tb/tb_tape_head_ctrl.sv
// Directed bench for tape_head_ctrl with a registered-read 256x8 tape memory model.
module tb_tape_head_ctrl;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_INC   = 3'd1;
  localparam logic [2:0] OP_DEC   = 3'd2;
  localparam logic [2:0] OP_RIGHT = 3'd3;
  localparam logic [2:0] OP_LEFT  = 3'd4;
  localparam logic [2:0] OP_OUT   = 3'd5;
  localparam logic [2:0] OP_IN    = 3'd6;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] cell_val, mem_address, mem_data, mem_q, ptr;
  logic       cell_zero, mem_wren;
`ifdef TAPE_BOUNDS_EN
  logic       err;
`endif
  logic [7:0] tb_mem [256];

  int checks   = 0;
  int failures = 0;

  tape_head_ctrl_if #(.DATA_W(8)) bus ();

  tape_head_ctrl #(.ADDR_W(8), .DATA_W(8), .CLEAR_ON_RESET(1'b1)) dut (
    .clock       (clock),
    .reset       (reset),
    .op_if       (bus),
    .cell_val    (cell_val),
    .cell_zero   (cell_zero),
    .ptr         (ptr),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .mem_q       (mem_q)
`ifdef TAPE_BOUNDS_EN
    ,
    .err         (err)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_wren) tb_mem[mem_address] <= mem_data;
    mem_q <= tb_mem[mem_address];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [7:0] data);
    bus.op_valid = 1'b1;
    bus.op       = op;
    bus.in_data  = data;
  endtask

  task automatic idle();
    bus.op_valid = 1'b0;
    bus.op       = OP_NOP;
    bus.in_data  = 8'h00;
  endtask

  // Called on a negedge right after reset is released; ends on a negedge with op_ready high.
  task automatic sweep_check(input string tag);
    int n = 0;
    int bad = 0;
    #1;
    while (!bus.op_ready && n < 300) begin
      if (!(mem_wren === 1'b1 && mem_address === n[7:0] && mem_data === 8'h00)) bad++;
      n++;
      @(negedge clock);
      #1;
    end
    check({tag, "_len"}, n, 256);
    check({tag, "_bad_writes"}, bad, 0);
    check({tag, "_ready"}, bus.op_ready, 1);
    check({tag, "_ptr"}, ptr, 0);
    check({tag, "_zero"}, cell_zero, 1);
    check({tag, "_mem255"}, tb_mem[255], 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) tb_mem[i] = 8'hAA;
    idle();

    // Reset state.
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_ready", bus.op_ready, 0);
    check("rst_ptr", ptr, 0);
    check("rst_cell", cell_val, 0);
    check("rst_outv", bus.out_valid, 0);
    check("rst_outd", bus.out_data, 0);
`ifdef TAPE_BOUNDS_EN
    check("rst_err", err, 0);
`endif
    reset = 1'b0;
    sweep_check("sweep1");

    // INC x3 then OUT.
    drive(OP_INC, 0); #1;
    check("inc1_wren", mem_wren, 1);
    check("inc1_addr", mem_address, 0);
    check("inc1_data", mem_data, 1);
    @(negedge clock); drive(OP_INC, 0); #1;
    check("inc2_data", mem_data, 2);
    @(negedge clock); drive(OP_INC, 0); #1;
    check("inc3_data", mem_data, 3);
    check("inc3_cell", cell_val, 2);
    @(negedge clock); drive(OP_OUT, 0); #1;
    check("out_wren", mem_wren, 0);
    check("out_cell", cell_val, 3);
    check("out_pre_valid", bus.out_valid, 0);
    @(negedge clock); idle(); #1;
    check("out_valid", bus.out_valid, 1);
    check("out_data", bus.out_data, 3);
    check("mem0_three", tb_mem[0], 3);
    @(negedge clock); #1;
    check("out_pulse_end", bus.out_valid, 0);

    // DEC down to 0, then wrap below 0 and back above 255.
    drive(OP_DEC, 0); #1;
    check("dec1_data", mem_data, 2);
    @(negedge clock); drive(OP_DEC, 0); #1;
    check("dec2_data", mem_data, 1);
    @(negedge clock); drive(OP_DEC, 0); #1;
    check("dec3_data", mem_data, 0);
    @(negedge clock); drive(OP_DEC, 0); #1;
    check("dec0_zero", cell_zero, 1);
    check("dec0_data", mem_data, 255);
    check("dec0_wren", mem_wren, 1);
    @(negedge clock); drive(OP_INC, 0); #1;
    check("dec0_cell", cell_val, 255);
    check("dec0_nz", cell_zero, 0);
    check("wrap_inc_data", mem_data, 0);

    // IN then INC forwards the just-written value.
    @(negedge clock); drive(OP_IN, 8'h40); #1;
    check("in_data", mem_data, 8'h40);
    check("in_wren", mem_wren, 1);
    @(negedge clock); drive(OP_INC, 0); #1;
    check("in_fwd_data", mem_data, 8'h41);

    // RIGHT: two cycles with op_ready low, fetch of cell 1 (zero).
    @(negedge clock); drive(OP_RIGHT, 0); #1;
    check("right_acc_cell", cell_val, 8'h41);
    check("right_acc_wren", mem_wren, 0);
    @(negedge clock); idle(); #1;
    check("right_fetch_ready", bus.op_ready, 0);
    check("right_fetch_addr", mem_address, 1);
    check("right_fetch_wren", mem_wren, 0);
    check("right_ptr", ptr, 1);
    @(negedge clock); #1;
    check("right_cap_ready", bus.op_ready, 0);
    check("right_cap_wren", mem_wren, 0);
    @(negedge clock); drive(OP_INC, 0); #1;
    check("right_done_ready", bus.op_ready, 1);
    check("right_cell", cell_val, 0);
    check("inc_c1_addr", mem_address, 1);
    check("inc_c1_data", mem_data, 1);

    // LEFT restores cell 0.
    @(negedge clock); drive(OP_LEFT, 0); #1;
    @(negedge clock); idle(); #1;
    check("left_fetch_ready", bus.op_ready, 0);
    check("left_fetch_addr", mem_address, 0);
    @(negedge clock); #1;
    check("left_cap_ready", bus.op_ready, 0);
    @(negedge clock); #1;
    check("left_done_ready", bus.op_ready, 1);
    check("left_cell", cell_val, 8'h41);
    check("left_ptr", ptr, 0);
    check("mem1_one", tb_mem[1], 1);

    // LEFT at ptr 0.
    drive(OP_LEFT, 0); #1;
    @(negedge clock); idle(); #1;
`ifdef TAPE_BOUNDS_EN
    check("bound_ready", bus.op_ready, 1);
    check("bound_ptr", ptr, 0);
    check("bound_err", err, 1);
    check("bound_cell", cell_val, 8'h41);
`else
    check("lwrap_ready", bus.op_ready, 0);
    check("lwrap_ptr", ptr, 255);
    check("lwrap_addr", mem_address, 255);
    @(negedge clock); #1;
    check("lwrap_cap_ready", bus.op_ready, 0);
    @(negedge clock); #1;
    check("lwrap_done_ready", bus.op_ready, 1);
    check("lwrap_cell", cell_val, 0);
    check("lwrap_zero", cell_zero, 1);
`endif

    // Reset asserted mid-FETCH restarts the sweep.
    @(negedge clock); drive(OP_OUT, 0);
    @(negedge clock); drive(OP_RIGHT, 0); #1;
    check("rf_outv_before", bus.out_valid, 1);
    @(negedge clock); idle(); reset = 1'b1; #1;
    check("rf_in_fetch", bus.op_ready, 0);
    @(negedge clock); #1;
    check("rf_ready", bus.op_ready, 0);
    check("rf_ptr", ptr, 0);
    check("rf_cell", cell_val, 0);
    check("rf_outv", bus.out_valid, 0);
    check("rf_wren", mem_wren, 1);
    check("rf_addr", mem_address, 0);
    reset = 1'b0;
    sweep_check("sweep2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tape_head_ctrl.md
Name: tape_head_ctrl

Overview:
- Data-path controller directly upstream of the 256x8 tape memory in the BF machine.
- Accepts decoded data-tape ops (+ - > < . ,) from the instruction sequencer over a valid/ready handshake.
- Owns the data pointer and a cached copy of the current cell, and drives the memory's address/data/wren port.
- Exports the current cell value and a zero flag to the branch unit for [ and ].

Parameters:
- ADDR_W, 8: tape address width; tape depth = 2^ADDR_W.
- DATA_W, 8: cell width.
- CLEAR_ON_RESET, 1: 1 = sweep-write 0 to every cell after reset; 0 = go straight to IDLE.

Ports:
- clock  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- op_valid  in  1  sequencer presents an op.
- op  in  3  0 NOP, 1 INC, 2 DEC, 3 RIGHT, 4 LEFT, 5 OUT, 6 IN, 7 reserved (treated as NOP).
- op_ready  out  1  controller can accept an op this cycle.
- in_data  in  DATA_W  input byte, sampled when IN is accepted.
- out_valid  out  1  one-cycle pulse carrying an OUT result.
- out_data  out  DATA_W  value emitted by OUT.
- cell_val  out  DATA_W  cached value of tape[ptr].
- cell_zero  out  1  cell_val == 0.
- ptr  out  ADDR_W  current data pointer.
- mem_address  out  ADDR_W  to tape memory.
- mem_data  out  DATA_W  to tape memory.
- mem_wren  out  1  to tape memory.
- mem_q  in  DATA_W  from tape memory; registered read, valid the cycle after the address is sampled.

Behaviour:
- Reset (synchronous, active-high):
  - ptr=0, cell_val=0, out_valid=0, out_data=0, err=0.
  - State goes to CLR if CLEAR_ON_RESET, else IDLE.
  - Reset asserted in any state, including mid-sweep or mid-fetch, aborts the operation; the next state is as above.
- States: CLR, IDLE, FETCH, CAPTURE.
- CLR:
  - op_ready=0, mem_wren=1, mem_data=0, mem_address=clr_cnt.
  - clr_cnt counts 0..2^ADDR_W-1, so the sweep takes exactly 256 cycles.
  - After the write to address 255, go to IDLE.
- IDLE: op_ready=1.
- Accepted op = op_valid & op_ready, handled combinationally on the accepting cycle:
  - INC/DEC: mem_address=ptr, mem_data=cell_val±1 mod 2^DATA_W, mem_wren=1. cell_val takes the new value at the clock edge. Stays in IDLE, so back-to-back INC/DEC run at one per cycle.
  - IN: same write path with mem_data=in_data; cell_val<=in_data.
  - OUT: out_data<=cell_val and out_valid=1 for exactly the following cycle. No memory access.
  - RIGHT/LEFT: ptr<=ptr±1 mod 2^ADDR_W, go to FETCH.
  - NOP/7: no effect.
- FETCH: op_ready=0, mem_address=ptr, mem_wren=0; go to CAPTURE.
- CAPTURE: op_ready=0; cell_val<=mem_q; go to IDLE.
- Move latency: 3 cycles from acceptance to op_ready high again. cell_val/cell_zero are stale until the cycle after CAPTURE.
- mem_wren is never asserted in FETCH or CAPTURE.
- When idle with no op, mem_address=ptr and mem_wren=0.
- Cell arithmetic wraps: 255+1=0 and 0-1=255. No saturation.
- INC immediately following IN uses the just-written value; the cached cell is the forwarding source.

Optional Feature:
- Macro: TAPE_BOUNDS_EN.
- Defined:
  - Adds output err (1 bit, reset 0, sticky until reset).
  - RIGHT at ptr=255 or LEFT at ptr=0 leaves ptr unchanged, sets err, skips FETCH/CAPTURE, and stays in IDLE (1-cycle op).
- Undefined:
  - No err port; the pointer wraps modulo 2^ADDR_W and performs a normal fetch.

Test Plan:
- Reset with CLEAR_ON_RESET=1 -> op_ready low exactly 256 cycles, mem_wren high with addresses 0..255 and data 0, then op_ready=1, ptr=0, cell_zero=1.
- INC x3 back-to-back, then OUT -> three writes to addr 0 of data 1,2,3 on consecutive cycles; out_valid single pulse with out_data=3.
- DEC at cell 0 -> mem_data=255 written, cell_val=255, cell_zero=0.
- IN 0x41, RIGHT, INC, LEFT -> RIGHT fetch returns 0; INC writes 1 to addr 1; LEFT fetch restores cell_val=0x41; each move holds op_ready low 2 cycles.
- LEFT at ptr=0 -> without TAPE_BOUNDS_EN, ptr=255 and tape[255] is fetched; with it, ptr=0, err=1, op_ready stays high.
- Reset asserted mid-FETCH -> next cycle in CLR, ptr=0, cell_val=0, out_valid=0, sweep restarts at address 0.
